// File: rtl/angle_to_servo_pwm_pkg.sv
// Shared types and constants for the angle-to-servo PWM block.
// Build option: SERVO_SLEW_EN (consumed by angle_slew) enables per-frame slew limiting.
package servo_pkg;

  localparam int ANGLE_W = 9;
  localparam int FRAME_W = 19;
  localparam logic [ANGLE_W-1:0] MAX_ANGLE = 9'd360;

  typedef enum logic {
    S_GAP   = 1'b0,
    S_PULSE = 1'b1
  } servo_state_t;

endpackage

// File: rtl/angle_to_servo_pwm_slew.sv
// Clamp of the commanded angle and the per-frame step toward it.
// Build option: SERVO_SLEW_EN limits each step to SLEW_DEG; otherwise the
// applied angle jumps straight to the clamped target.
module angle_slew
  import servo_pkg::*;
#(
  parameter int SLEW_DEG = 10
) (
  input  logic [ANGLE_W-1:0] angle,
  input  logic [ANGLE_W-1:0] cur,
  output logic [ANGLE_W-1:0] tgt_next,
  output logic [ANGLE_W-1:0] cur_next
);

  if (SLEW_DEG < 1 || SLEW_DEG > 360) begin : g_slew_chk
    $error("angle_slew: SLEW_DEG must be in 1..360");
  end

`ifdef SERVO_SLEW_EN
  localparam logic [ANGLE_W-1:0] SLEW = ANGLE_W'(SLEW_DEG);
`endif

  // Clamp the command, then step the applied angle toward it.
  always_comb begin
    tgt_next = (angle > MAX_ANGLE) ? MAX_ANGLE : angle;
    cur_next = tgt_next;
`ifdef SERVO_SLEW_EN
    // A step that would reach or pass the target lands exactly on it, so a
    // reversed target never causes overshoot.
    if (tgt_next > cur) begin
      if ((tgt_next - cur) > SLEW) cur_next = cur + SLEW;
    end else if ((cur - tgt_next) > SLEW) begin
      cur_next = cur - SLEW;
    end
`else
    // Without slew the target is taken as-is; the equal case keeps cur.
    if (cur == tgt_next) cur_next = cur;
`endif
  end

endmodule

// File: rtl/angle_to_servo_pwm.sv
// Hobby-servo PWM generator: one pulse per frame, width linear in angle.
// The angle command is sampled only at frame boundaries, so the width never
// changes inside a frame.
// Build option: SERVO_SLEW_EN (see angle_slew) ramps the applied angle.
module angle_to_servo_pwm
  import servo_pkg::*;
#(
  parameter int CLKS_PER_FRAME = 500000,
  parameter int MIN_PULSE_CLKS = 25000,
  parameter int CLKS_PER_DEG   = 69,
  parameter int SLEW_DEG       = 10
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [ANGLE_W-1:0] i_Angle,
  output logic               o_Servo_PWM,
  output logic               o_Frame_Start,
  output logic               o_Moving,
  output logic [ANGLE_W-1:0] o_Cur_Angle
);

  if (MIN_PULSE_CLKS + 360 * CLKS_PER_DEG >= CLKS_PER_FRAME) begin : g_width_chk
    $error("angle_to_servo_pwm: full-scale pulse does not fit in the frame");
  end
  if (CLKS_PER_FRAME < 2 || CLKS_PER_FRAME > (1 << FRAME_W)) begin : g_frame_chk
    $error("angle_to_servo_pwm: CLKS_PER_FRAME out of counter range");
  end

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(CLKS_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] MIN_P      = FRAME_W'(MIN_PULSE_CLKS);
  localparam logic [FRAME_W-1:0] DEG_P      = FRAME_W'(CLKS_PER_DEG);

  logic [FRAME_W-1:0] frame_cnt;
  logic [FRAME_W-1:0] frame_cnt_next;
  logic               boundary;
  logic [ANGLE_W-1:0] cur_angle;
  logic [ANGLE_W-1:0] tgt_angle;
  logic [ANGLE_W-1:0] cur_next;
  logic [ANGLE_W-1:0] tgt_next;
  logic [FRAME_W-1:0] pulse_clks;
  logic [FRAME_W-1:0] pulse_next;
  servo_state_t       state;

  angle_slew #(
    .SLEW_DEG(SLEW_DEG)
  ) u_slew (
    .angle    (i_Angle),
    .cur      (cur_angle),
    .tgt_next (tgt_next),
    .cur_next (cur_next)
  );

  // Frame position decode; the boundary is the edge where the counter wraps.
  always_comb begin
    boundary       = (frame_cnt == FRAME_LAST);
    frame_cnt_next = boundary ? '0 : frame_cnt + 1'b1;
    pulse_next     = MIN_P + FRAME_W'(cur_next) * DEG_P;
  end

  // Frame counter; resets to the last count so the first edge starts a frame.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) frame_cnt <= FRAME_LAST;
    else       frame_cnt <= frame_cnt_next;
  end

  // Pulse FSM with angle latching and registered outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state         <= S_GAP;
      cur_angle     <= '0;
      tgt_angle     <= '0;
      pulse_clks    <= MIN_P;
      o_Servo_PWM   <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Moving      <= 1'b0;
    end else if (boundary) begin
      tgt_angle     <= tgt_next;
      cur_angle     <= cur_next;
      pulse_clks    <= pulse_next;
      state         <= S_PULSE;
      o_Servo_PWM   <= 1'b1;
      o_Frame_Start <= 1'b1;
      o_Moving      <= (cur_next != tgt_next);
    end else begin
      o_Frame_Start <= 1'b0;
      if (state == S_PULSE && frame_cnt_next == pulse_clks) begin
        state       <= S_GAP;
        o_Servo_PWM <= 1'b0;
      end
    end
  end

  assign o_Cur_Angle = cur_angle;

endmodule

// File: tb/tb_angle_to_servo_pwm.sv
// Directed bench for angle_to_servo_pwm with a small frame (1000 clocks).
module tb_angle_to_servo_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] angle;
  logic       pwm;
  logic       fs;
  logic       moving;
  logic [8:0] cur;

  int n_vec = 0;
  int n_err = 0;
  int exp_cur = 0;
  int exp_tgt = 0;

  angle_to_servo_pwm #(
    .CLKS_PER_FRAME(1000),
    .MIN_PULSE_CLKS(100),
    .CLKS_PER_DEG  (1),
    .SLEW_DEG      (10)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Angle      (angle),
    .o_Servo_PWM  (pwm),
    .o_Frame_Start(fs),
    .o_Moving     (moving),
    .o_Cur_Angle  (cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int clamp_m(input int a);
    return (a > 360) ? 360 : a;
  endfunction

  function automatic int step_m(input int c, input int t);
`ifdef SERVO_SLEW_EN
    if (t > c) return (t - c > 10) ? c + 10 : t;
    else       return (c - t > 10) ? c - 10 : t;
`else
    return t;
`endif
  endfunction

  // Waits (bounded) for the frame-start strobe; returns cycles waited.
  task automatic wait_fs(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (fs !== 1'b1 && c < 2000);
  endtask

  // Entered at the negedge where o_Frame_Start is seen. Checks the frame and
  // changes i_Angle 50 cycles into the pulse; returns at the next frame start.
  task automatic do_frame(input logic [8:0] next_angle);
    int  w;
    int  g;
    bit  applied;
    exp_tgt = clamp_m(int'(angle));
    exp_cur = step_m(exp_cur, exp_tgt);
    check("cur_angle", 32'(cur), 32'(exp_cur));
    check("moving", 32'(moving), 32'(exp_cur != exp_tgt));
    w = 0;
    applied = 1'b0;
    while (pwm === 1'b1 && w < 1001) begin
      if (w == 50) begin
        angle = next_angle;
        applied = 1'b1;
      end
      w++;
      @(negedge clk);
      if (w == 1) check("fs_one_cycle", 32'(fs), 32'd0);
    end
    if (!applied) angle = next_angle;
    check("pulse_width", 32'(w), 32'(100 + exp_cur));
    g = 0;
    while (fs !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("frame_period", 32'(w + g), 32'd1000);
  endtask

  initial begin
    int c;
    rst   = 1'b1;
    angle = 9'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_fs", 32'(fs), 32'd0);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_cur", 32'(cur), 32'd0);

    rst = 1'b0;
    wait_fs(c);
    check("first_frame_latency", 32'(c), 32'd1);
    check("first_pwm", 32'(pwm), 32'd1);

    // Idle at 0 degrees.
    do_frame(9'd0);
    do_frame(9'd0);
    // Jump toward 270, then back to 0.
    do_frame(9'd270);
    do_frame(9'd0);
    do_frame(9'd0);
    do_frame(9'd0);
    // Ramp 0 -> 90.
    do_frame(9'd90);
    for (int i = 0; i < 10; i++) do_frame(9'd90);
    check("settled_90", 32'(cur), 32'd90);
    // Mid-pulse change 90 -> 180, then overrange command.
    do_frame(9'd180);
    do_frame(9'd511);
    for (int i = 0; i < 20; i++) do_frame(9'd511);
    check("clamped_360", 32'(cur), 32'd360);

    // Reset 50 cycles into the 460-cycle pulse.
    repeat (50) @(negedge clk);
    check("pwm_before_rst", 32'(pwm), 32'd1);
    rst = 1'b1;
    #1;
    check("pwm_async_drop", 32'(pwm), 32'd0);
    check("cur_after_rst", 32'(cur), 32'd0);
    angle = 9'd0;
    exp_cur = 0;
    repeat (3) @(negedge clk);
    check("pwm_held_in_rst", 32'(pwm), 32'd0);
    rst = 1'b0;
    wait_fs(c);
    check("restart_latency", 32'(c), 32'd1);
    do_frame(9'd0);
    do_frame(9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/angle_to_servo_pwm.md
# angle_to_servo_pwm

Converts a 9-bit angle command (0–360 degrees, produced by the switch-to-angle stage) into a hobby-servo PWM waveform: one pulse per fixed frame, pulse width linear in angle. The command is sampled only at frame boundaries. With slew limiting compiled in, the applied angle walks toward the target by a bounded step per frame. It sits directly downstream of the switch decoder and drives the servo output pin.

## Interface
- CLKS_PER_FRAME, 500000, frame period in clocks (20 ms at 25 MHz).
- MIN_PULSE_CLKS, 25000, pulse width at 0 degrees (1 ms).
- CLKS_PER_DEG, 69, added pulse clocks per degree. 360 degrees gives 49840 clocks.
- SLEW_DEG, 10, maximum applied-angle change per frame (only used with slew compiled in).
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Angle  in  9  target angle in degrees; values >360 clamp to 360.
- o_Servo_PWM  out  1  servo pulse, registered.
- o_Frame_Start  out  1  one-cycle strobe on the first cycle of each frame.
- o_Moving  out  1  high while applied angle ≠ clamped target latched at the last boundary.
- o_Cur_Angle  out  9  angle currently applied to the pulse width.

## Operation
- **Registers**
  - frame_cnt: 19 bits, counts 0..CLKS_PER_FRAME-1, then wraps.
  - cur_angle: 9 bits.
  - tgt_angle: 9 bits.
  - pulse_clks: 19 bits.
  - state: S_GAP or S_PULSE.
- **Reset values**
  - frame_cnt = CLKS_PER_FRAME-1.
  - cur_angle = tgt_angle = 0.
  - pulse_clks = MIN_PULSE_CLKS.
  - state = S_GAP.
  - All outputs 0.
- **Boundary edge** (the edge where frame_cnt wraps to 0):
  - tgt_angle ← clamp(i_Angle).
  - cur_angle ← step(cur_angle, tgt_angle).
  - pulse_clks ← MIN_PULSE_CLKS + cur_angle_next*CLKS_PER_DEG. This is a constant multiply, computed from the next value.
  - state → S_PULSE.
  - o_Servo_PWM ← 1.
  - o_Frame_Start ← 1.
- **S_PULSE → S_GAP** when frame_cnt_next == pulse_clks. o_Servo_PWM ← 0 on the same edge.
- **S_GAP** holds until the next boundary edge.
- **step()**
  - Slew compiled in: move toward the target by min(SLEW_DEG, |tgt-cur|).
  - Slew compiled out: cur ← tgt.
- o_Moving is registered as (cur_angle_next ≠ tgt_angle_next).
- i_Angle changes mid-frame are ignored until the next boundary. The pulse width never changes inside a frame.
- Target equal to current: no step, o_Moving = 0.
- Target reversing during a ramp: the step direction follows the new target at the next boundary. No overshoot.
- Elaboration check: MIN_PULSE_CLKS + 360*CLKS_PER_DEG < CLKS_PER_FRAME. If violated, raise an error.

## Timing
- The first edge after reset release is a boundary edge, so frame 0 starts immediately.
- o_Servo_PWM is high for exactly pulse_clks cycles per frame, with period exactly CLKS_PER_FRAME.
- Latency from i_Angle change to its first use: up to CLKS_PER_FRAME cycles. The new width appears in the pulse starting on that boundary edge.
- Full-range ramp with slew: ceil(360/SLEW_DEG) frames. This is 36 frames at the default SLEW_DEG.
- Reset asserted mid-pulse drops o_Servo_PWM asynchronously. No runt pulse is completed.

## Configuration
- SERVO_SLEW_EN defined: per-frame step is limited to SLEW_DEG, and o_Moving can stay high for many frames.
- SERVO_SLEW_EN undefined: the applied angle jumps to the target at the next boundary, and o_Moving is never 1 after that boundary edge.

## Structure
- Package servo_pkg holds:
  - ANGLE_W = 9.
  - MAX_ANGLE = 360.
  - The state encoding S_GAP/S_PULSE.
  - The frame counter width (19).
- Sub-module angle_slew holds the clamp and step() logic, as pure combinational logic instantiated once. The slew ifdef lives there.
- Top level holds the counter, FSM and output registers.

## Test plan
Parameters for all cases: CLKS_PER_FRAME=1000, MIN_PULSE_CLKS=100, CLKS_PER_DEG=1, SLEW_DEG=10.
- Reset release with i_Angle=0:
  - PWM high 100 cycles, low 900, repeating.
  - o_Frame_Start every 1000 cycles.
  - o_Cur_Angle=0.
- SERVO_SLEW_EN off, i_Angle=270: from the next frame, pulse = 370 cycles, o_Moving=0.
- SERVO_SLEW_EN on, i_Angle 0→90:
  - Pulses 110, 120 … 190 over 9 frames.
  - o_Moving high through frame 8, low from frame 9.
- i_Angle=511: clamped; the final pulse is 460 cycles and o_Cur_Angle=360.
- i_Angle toggled 90→180 mid-pulse: the current pulse width is unchanged, and the new width takes effect at the next boundary.
- i_Rst asserted 50 cycles into a 460-cycle pulse:
  - PWM drops immediately.
  - After release, PWM rises on the first edge with a 100-cycle pulse when i_Angle=0.
